// File: rtl/demux_1to2_4bit.sv
// demux_1to2_4bit: routes a valid/ready input word to one of two
// one-entry output registers (A when sel=0, B when sel=1).
// Each channel drains independently via its own valid/ready pair.
// Optional feature macro: DEMUX_CNT_EN adds 8-bit delivered-word
// counters a_count / b_count (wrapping 255 -> 0).
module demux_1to2_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] A,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] B,
  output logic             b_valid,
  input  logic             b_ready
`ifdef DEMUX_CNT_EN
  ,
  output logic [7:0]       a_count,
  output logic [7:0]       b_count
`endif
);

  // Channel index 0 is A, index 1 is B.
  logic [WIDTH-1:0] data_q [2];
  logic [1:0]       valid_q;
  logic [1:0]       out_ready;
  logic [1:0]       free;
  logic [1:0]       load;
  logic [1:0]       drain;
  logic             in_hs;

  assign out_ready = {b_ready, a_ready};

  // A slot can take a new word if it is empty or is being drained this
  // cycle; in_ready looks only at the selected slot and never at in_valid.
  assign in_ready = ~rst & (sel ? free[1] : free[0]);
  assign in_hs    = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [WIDTH-1:0] data_reg;
      logic             valid_reg;

      assign free[gi]  = ~valid_reg | out_ready[gi];
      assign drain[gi] = valid_reg & out_ready[gi];
      assign load[gi]  = in_hs & (sel == 1'(gi));

      // One-entry register: reset wins, then load (covers drain+load
      // with no bubble), then drain clears valid; data holds otherwise.
      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg  <= '0;
          valid_reg <= 1'b0;
        end else if (load[gi]) begin
          data_reg  <= D;
          valid_reg <= 1'b1;
        end else if (drain[gi]) begin
          valid_reg <= 1'b0;
        end
      end

      assign data_q[gi]  = data_reg;
      assign valid_q[gi] = valid_reg;
    end
  endgenerate

  assign A       = data_q[0];
  assign a_valid = valid_q[0];
  assign B       = data_q[1];
  assign b_valid = valid_q[1];

`ifdef DEMUX_CNT_EN
  logic [7:0] cnt_q [2];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [7:0] cnt_reg;

      // Count output handshakes; natural 8-bit wrap gives 255 -> 0.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= 8'd0;
        end else if (drain[gi]) begin
          cnt_reg <= cnt_reg + 8'd1;
        end
      end

      assign cnt_q[gi] = cnt_reg;
    end
  endgenerate

  assign a_count = cnt_q[0];
  assign b_count = cnt_q[1];
`endif

endmodule

// File: tb/tb_demux_1to2_4bit.sv
// Testbench for demux_1to2_4bit: scenario tasks drive stimulus and make
// inline checks; a negedge scoreboard tracks per-channel queues of
// accepted words and compares them when each output handshake occurs.
module tb_demux_1to2_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] D;
  logic       sel;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] A;
  logic       a_valid;
  logic       a_ready;
  logic [3:0] B;
  logic       b_valid;
  logic       b_ready;
`ifdef DEMUX_CNT_EN
  logic [7:0] a_count;
  logic [7:0] b_count;
  logic [7:0] exp_a_cnt = 8'd0;
  logic [7:0] exp_b_cnt = 8'd0;
`endif

  int errors = 0;
  int checks = 0;

  // Scoreboard state: queues of accepted words and last loaded value.
  logic [3:0] qa[$];
  logic [3:0] qb[$];
  logic [3:0] last_a = 4'h0;
  logic [3:0] last_b = 4'h0;
  logic [3:0] w;
  logic       exp_ready;
  bit         verbose = 1'b1;

  always #5 clk = ~clk;

  demux_1to2_4bit #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .D        (D),
    .sel      (sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .B        (B),
    .b_valid  (b_valid),
    .b_ready  (b_ready)
`ifdef DEMUX_CNT_EN
    ,
    .a_count  (a_count),
    .b_count  (b_count)
`endif
  );

  // Scoreboard: check DUT against model, then advance the model by what
  // the coming rising edge will do with the inputs now on the pins.
  always @(negedge clk) begin
    checks++;
    if (a_valid !== (qa.size() != 0) || A !== last_a) begin
      errors++;
      $display("FAIL sb_chan_a: A=%h a_valid=%b, expected A=%h a_valid=%b",
               A, a_valid, last_a, qa.size() != 0);
    end
    checks++;
    if (b_valid !== (qb.size() != 0) || B !== last_b) begin
      errors++;
      $display("FAIL sb_chan_b: B=%h b_valid=%b, expected B=%h b_valid=%b",
               B, b_valid, last_b, qb.size() != 0);
    end
    exp_ready = rst ? 1'b0 : (sel ? (qb.size() == 0 || b_ready)
                                  : (qa.size() == 0 || a_ready));
    checks++;
    if (in_ready !== exp_ready) begin
      errors++;
      $display("FAIL sb_in_ready: got %b expected %b (sel=%b)", in_ready, exp_ready, sel);
    end
`ifdef DEMUX_CNT_EN
    checks++;
    if (a_count !== exp_a_cnt || b_count !== exp_b_cnt) begin
      errors++;
      $display("FAIL sb_counts: a_count=%0d b_count=%0d expected %0d %0d",
               a_count, b_count, exp_a_cnt, exp_b_cnt);
    end
`endif
    if (rst) begin
      qa.delete();
      qb.delete();
      last_a = 4'h0;
      last_b = 4'h0;
`ifdef DEMUX_CNT_EN
      exp_a_cnt = 8'd0;
      exp_b_cnt = 8'd0;
`endif
    end else begin
      if (qa.size() != 0 && a_ready) begin
        w = qa.pop_front();
        checks++;
        if (A !== w) begin
          errors++;
          $display("FAIL sb_deliver_a: got %h expected %h", A, w);
        end
        if (verbose) $display("deliver A %h", A);
`ifdef DEMUX_CNT_EN
        exp_a_cnt = exp_a_cnt + 8'd1;
`endif
      end
      if (qb.size() != 0 && b_ready) begin
        w = qb.pop_front();
        checks++;
        if (B !== w) begin
          errors++;
          $display("FAIL sb_deliver_b: got %h expected %h", B, w);
        end
        if (verbose) $display("deliver B %h", B);
`ifdef DEMUX_CNT_EN
        exp_b_cnt = exp_b_cnt + 8'd1;
`endif
      end
      if (in_valid && exp_ready) begin
        if (sel) begin
          qb.push_back(D);
          last_b = D;
        end else begin
          qa.push_back(D);
          last_a = D;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; sel = 1'b0; D = 4'hF;
    a_ready = 1'b0; b_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    tick();
    tick();
    checks++;
    if (A !== 4'h0 || B !== 4'h0 || a_valid !== 1'b0 || b_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: A=%h B=%h av=%b bv=%b expected 0 0 0 0",
               A, B, a_valid, b_valid);
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_basic();
    in_valid = 1'b1; sel = 1'b0; D = 4'hA; a_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (A !== 4'hA || a_valid !== 1'b1 || b_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_load: A=%h av=%b bv=%b in_ready=%b expected A 1 0 0",
               A, a_valid, b_valid, in_ready);
    end
  endtask

  task automatic test_independent();
    in_valid = 1'b1; sel = 1'b1; D = 4'h5; b_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (B !== 4'h5 || b_valid !== 1'b1 || A !== 4'hA || a_valid !== 1'b1) begin
      errors++;
      $display("FAIL indep_load_b: B=%h bv=%b A=%h av=%b expected 5 1 A 1",
               B, b_valid, A, a_valid);
    end
    tick();
    checks++;
    if (b_valid !== 1'b0 || A !== 4'hA || a_valid !== 1'b1) begin
      errors++;
      $display("FAIL indep_drain_b: bv=%b A=%h av=%b expected 0 A 1", b_valid, A, a_valid);
    end
  endtask

  task automatic test_stall();
    a_ready = 1'b0; sel = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      D = 4'(i + 3);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_in_ready: cycle %0d got %b expected 0", i, in_ready);
      end
      tick();
      checks++;
      if (A !== 4'hA || a_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d A=%h av=%b expected A 1", i, A, a_valid);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    a_ready = 1'b1; sel = 1'b0; in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      D = 4'(i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_in_ready: word %0d got %b expected 1", i, in_ready);
      end
      tick();
      checks++;
      if (A !== 4'(i) || a_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_stream: A=%h av=%b expected %h 1", A, a_valid, 4'(i));
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_stall();
    a_ready = 1'b0; b_ready = 1'b0; in_valid = 1'b1; sel = 1'b0; D = 4'hA;
    tick();
    sel = 1'b1; D = 4'h7;
    tick();
    rst = 1'b1; sel = 1'b0; D = 4'hC;
    tick();
    checks++;
    if (A !== 4'h0 || B !== 4'h0 || a_valid !== 1'b0 || b_valid !== 1'b0) begin
      errors++;
      $display("FAIL midstall_reset: A=%h B=%h av=%b bv=%b expected 0 0 0 0",
               A, B, a_valid, b_valid);
    end
    rst = 1'b0; D = 4'h3;
    tick();
    in_valid = 1'b0;
    checks++;
    if (A !== 4'h3 || a_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_accept: A=%h av=%b expected 3 1", A, a_valid);
    end
    a_ready = 1'b1;
    tick();
  endtask

`ifdef DEMUX_CNT_EN
  task automatic test_count_wrap();
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0; verbose = 1'b0;
    a_ready = 1'b1; b_ready = 1'b0; sel = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 257; i++) begin
      D = 4'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    verbose = 1'b1;
    checks++;
    if (a_count !== 8'd1 || b_count !== 8'd0) begin
      errors++;
      $display("FAIL count_wrap: a_count=%0d b_count=%0d expected 1 0", a_count, b_count);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      in_valid = 1'($urandom_range(0, 1));
      sel      = 1'($urandom_range(0, 1));
      D        = 4'($urandom_range(0, 15));
      a_ready  = ($urandom_range(0, 2) != 0);
      b_ready  = ($urandom_range(0, 2) != 0);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_independent();
    test_stall();
    test_back_to_back();
    test_reset_mid_stall();
`ifdef DEMUX_CNT_EN
    test_count_wrap();
`endif
    test_random();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_1to2_4bit.md
DEMUX_1TO2_4BIT -- requirements
Module: demux_1to2_4bit

Interface
REQ-001 Parameter: WIDTH, default 4, data width of the input and both output channels.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 D  input  WIDTH  input data word.
REQ-005 sel  input  1  destination select: 0 routes to channel A, 1 routes to channel B; sampled with D.
REQ-006 in_valid  input  1  D/sel valid.
REQ-007 in_ready  output  1  block can accept D this cycle.
REQ-008 A  output  WIDTH  channel A data register.
REQ-009 a_valid  output  1  A holds an undelivered word.
REQ-010 a_ready  input  1  channel A consumer accepts.
REQ-011 B  output  WIDTH  channel B data register.
REQ-012 b_valid  output  1  B holds an undelivered word.
REQ-013 b_ready  input  1  channel B consumer accepts.
REQ-014 a_count, b_count  output  8 each  delivered-word counters; present only with DEMUX_CNT_EN.

Function
REQ-015 Each channel SHALL be a one-entry register; slot X is "free" when x_valid=0 or x_ready=1.
REQ-016 in_ready SHALL be combinational: free(A) when sel=0, free(B) when sel=1; it SHALL NOT depend on in_valid.
REQ-017 Input handshake = in_valid & in_ready; on handshake the selected register SHALL load D and set its valid on the next edge (latency 1 cycle).
REQ-018 Output handshake = x_valid & x_ready; this SHALL clear x_valid on the next edge unless a load into X occurs in the same cycle.
REQ-019 Simultaneous drain and load of one channel: x_valid SHALL stay 1 and X SHALL take the new D; no bubble, no loss.
REQ-020 The unselected channel's data and valid SHALL hold, except for its own drain per REQ-018.
REQ-021 X data SHALL NOT change while x_valid=1 and x_ready=0 (stall stability).
REQ-022 in_valid with in_ready=0 SHALL NOT modify any state; the producer holds D/sel.
REQ-023 Channels SHALL be independent; the A state never blocks B traffic and vice versa.
REQ-024 Output data bits are don't-care while valid=0 but SHALL retain the last loaded value.

Reset
REQ-025 rst=1 at an edge SHALL force A=0, B=0, a_valid=0, b_valid=0 and the counters to 0, overriding any concurrent handshake.
REQ-026 While rst=1, in_ready SHALL be 0; words presented are discarded; words held mid-stall are dropped.
REQ-027 First accept SHALL be possible on the first edge after rst deasserts.

Configuration
REQ-028 Macro DEMUX_CNT_EN: when defined, a_count and b_count SHALL exist; each SHALL increment by 1 on its channel's output handshake, wrapping 255->0.
REQ-029 Without DEMUX_CNT_EN the counter ports and logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 After reset: in_valid=1, sel=0, D=4'hA, a_ready=0 -> next cycle A=4'hA, a_valid=1, b_valid=0; in_ready=0 while sel=0.
REQ-031 With A stalled: sel=1, D=4'h5, b_ready=1 -> B=4'h5 delivered; A stays 4'hA and a_valid stays 1 throughout.
REQ-032 Back-to-back streaming: a_ready=1, sel=0, D=1,2,3 on consecutive cycles -> A=1,2,3 on consecutive cycles, a_valid continuously 1, in_ready continuously 1.
REQ-033 Reset mid-stall: a_valid=1, A=4'hA, rst pulsed with in_valid=1 -> next cycle all valids 0, A=B=0, counters 0.
REQ-034 DEMUX_CNT_EN: 257 A handshakes -> a_count=1 (wrap); b_count unchanged.
REQ-035 Stall stability: a_ready=0 for 10 cycles, in_valid=1 with sel=0 and varying D -> A unchanged, in_ready=0 all 10 cycles.
